// File: rtl/cr_huf_compPKG.sv
// cr_huf_compPKG: Huffman compressor types and constants
package cr_huf_compPKG;
  typedef enum logic [1:0] {ACCUM, HANDOFF, CLEAR} e_sfc_state;
  localparam int SFC_FREQ_MAX = 32767;
endpackage

// File: rtl/cr_structs.sv
// cr_structs: shared pipeline types and the sequence-id width used across the compressor
`ifndef CREOLE_HC_SEQID_WIDTH
`define CREOLE_HC_SEQID_WIDTH 8
`endif
package cr_structs;
  typedef enum logic [1:0] {MIDDLE = 2'd0, END = 2'd1, PASS_THRU = 2'd2, FLUSH = 2'd3} e_pipe_eob;
endpackage

// File: rtl/cr_huf_comp_sfc_lane_merge.sv
// cr_huf_comp_sfc_lane_merge: per-counter 0/1/2 increments and beat min/max from two symbol lanes
module cr_huf_comp_sfc_lane_merge #(
  parameter int DAT_WIDTH = 10,
  parameter int MAX_NUM_SYM_USED = 576
) (
  input  logic [1:0]                        sym_vld,
  input  logic [DAT_WIDTH-1:0]              sym0,
  input  logic [DAT_WIDTH-1:0]              sym1,
  output logic [MAX_NUM_SYM_USED-1:0][1:0]  inc,
  output logic [DAT_WIDTH-1:0]              lo,
  output logic [DAT_WIDTH-1:0]              hi
);
  localparam logic [DAT_WIDTH:0] NUM_SYM = (DAT_WIDTH+1)'(MAX_NUM_SYM_USED);
  localparam logic [DAT_WIDTH-1:0] SYM_LAST = DAT_WIDTH'(MAX_NUM_SYM_USED - 1);
  logic v0, v1;
  logic [DAT_WIDTH-1:0] lo0, hi0;
  always_comb begin
    v0 = sym_vld[0] && ({1'b0, sym0} < NUM_SYM);
    v1 = sym_vld[1] && ({1'b0, sym1} < NUM_SYM);
    lo0 = v0 ? sym0 : SYM_LAST;
    hi0 = v0 ? sym0 : '0;
    lo = (v1 && sym1 < lo0) ? sym1 : lo0;
    hi = (v1 && sym1 > hi0) ? sym1 : hi0;
    for (int i = 0; i < MAX_NUM_SYM_USED; i++)
      inc[i] = {1'b0, v0 && sym0 == DAT_WIDTH'(i)} + {1'b0, v1 && sym1 == DAT_WIDTH'(i)};
  end
endmodule

// File: rtl/cr_huf_comp_sym_freq_counter.sv
// cr_huf_comp_sym_freq_counter: per-block symbol histogram for the sorter; CR_HUF_COMP_SFC_FORCE_EOB_SYM_EN forces symbol 256
`ifndef CREOLE_HC_SEQID_WIDTH
`define CREOLE_HC_SEQID_WIDTH 8
`endif
module cr_huf_comp_sym_freq_counter
  import cr_structs::*;
  import cr_huf_compPKG::*;
#(
  parameter int DAT_WIDTH        = 10,
  parameter int SYM_FREQ_WIDTH   = $clog2(SFC_FREQ_MAX + 1),
  parameter int CNTRL_WIDTH      = 1,
  parameter int MAX_NUM_SYM_USED = 576
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               in_vld,
  input  logic [1:0]                                         in_sym_vld,
  input  logic [DAT_WIDTH-1:0]                               in_sym0,
  input  logic [DAT_WIDTH-1:0]                               in_sym1,
  input  logic [CNTRL_WIDTH-1:0]                             in_meta,
  input  logic [`CREOLE_HC_SEQID_WIDTH-1:0]                  in_seq_id,
  input  e_pipe_eob                                          in_eob,
  output logic                                               not_ready,
  input  logic                                               is_not_ready,
  output logic [MAX_NUM_SYM_USED-1:0][SYM_FREQ_WIDTH-1:0]    fc_is_new_freq,
  output logic [DAT_WIDTH-1:0]                               fc_is_sym_lo,
  output logic [DAT_WIDTH-1:0]                               fc_is_sym_hi,
  output logic [CNTRL_WIDTH-1:0]                             fc_is_meta,
  output logic [`CREOLE_HC_SEQID_WIDTH-1:0]                  fc_is_seq_id,
  output e_pipe_eob                                          fc_is_eob
);
  localparam logic [DAT_WIDTH-1:0] SYM_LAST = DAT_WIDTH'(MAX_NUM_SYM_USED - 1);
`ifdef CR_HUF_COMP_SFC_FORCE_EOB_SYM_EN
  localparam logic [DAT_WIDTH-1:0] EOB_SYM = DAT_WIDTH'(256);
`endif
  e_sfc_state state_q, state_d;
  logic [MAX_NUM_SYM_USED-1:0][SYM_FREQ_WIDTH-1:0] cnt_q, cnt_d, cnt_upd;
  logic [MAX_NUM_SYM_USED-1:0][1:0] inc;
  logic [DAT_WIDTH-1:0] lo_q, lo_d, hi_q, hi_d, beat_lo, beat_hi;
  logic [CNTRL_WIDTH-1:0] meta_q, meta_d;
  logic [`CREOLE_HC_SEQID_WIDTH-1:0] seq_id_q, seq_id_d;
  e_pipe_eob eob_q, eob_d;
  logic acc, last, pass;
  logic [SYM_FREQ_WIDTH:0] sum;

  cr_huf_comp_sfc_lane_merge #(
    .DAT_WIDTH(DAT_WIDTH),
    .MAX_NUM_SYM_USED(MAX_NUM_SYM_USED)
  ) u_lane_merge (
    .sym_vld(in_sym_vld),
    .sym0(in_sym0),
    .sym1(in_sym1),
    .inc(inc),
    .lo(beat_lo),
    .hi(beat_hi)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ACCUM;
      cnt_q    <= '0;
      lo_q     <= SYM_LAST;
      hi_q     <= '0;
      meta_q   <= '0;
      seq_id_q <= '0;
      eob_q    <= MIDDLE;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      meta_q   <= meta_d;
      seq_id_q <= seq_id_d;
      eob_q    <= eob_d;
    end
  end

  always_comb
    state_d = state_q == ACCUM   ? ((in_vld && in_eob != MIDDLE) ? HANDOFF : ACCUM) :
              state_q == HANDOFF ? (is_not_ready ? HANDOFF : CLEAR) : ACCUM;

  always_comb begin
    acc = state_q == ACCUM && in_vld;
    last = acc && in_eob != MIDDLE;
    pass = in_eob == PASS_THRU;
    sum = '0;
    for (int i = 0; i < MAX_NUM_SYM_USED; i++) begin
      sum = {1'b0, cnt_q[i]} + (SYM_FREQ_WIDTH+1)'(inc[i]);
      cnt_upd[i] = sum[SYM_FREQ_WIDTH] ? '1 : sum[SYM_FREQ_WIDTH-1:0];
    end
    cnt_d = cnt_q;
    lo_d = lo_q;
    hi_d = hi_q;
    meta_d = last ? in_meta : meta_q;
    seq_id_d = last ? in_seq_id : seq_id_q;
    eob_d = last ? in_eob : eob_q;
    if (state_q == CLEAR) begin
      cnt_d = '0;
      lo_d = SYM_LAST;
      hi_d = '0;
    end else if (last && pass) begin
      cnt_d = '0;
      lo_d = '0;
      hi_d = '0;
    end else if (acc) begin
      cnt_d = cnt_upd;
      lo_d = beat_lo < lo_q ? beat_lo : lo_q;
      hi_d = beat_hi > hi_q ? beat_hi : hi_q;
      if (last) begin
`ifdef CR_HUF_COMP_SFC_FORCE_EOB_SYM_EN
        cnt_d[256] = cnt_d[256] == '0 ? SYM_FREQ_WIDTH'(1) : cnt_d[256];
        lo_d = lo_d > EOB_SYM ? EOB_SYM : lo_d;
        hi_d = hi_d < EOB_SYM ? EOB_SYM : hi_d;
`endif
        // lo above hi means nothing was counted: report an empty range as 0..0
        if (lo_d > hi_d) begin
          lo_d = '0;
          hi_d = '0;
        end
      end
    end
  end

  always_comb begin
    not_ready = state_q != ACCUM;
    fc_is_eob = (state_q == HANDOFF && !is_not_ready) ? eob_q : MIDDLE;
    fc_is_new_freq = cnt_q;
    fc_is_sym_lo = lo_q;
    fc_is_sym_hi = hi_q;
    fc_is_meta = meta_q;
    fc_is_seq_id = seq_id_q;
  end
endmodule

// File: doc/cr_huf_comp_sym_freq_counter.md
Name: cr_huf_comp_sym_freq_counter

Overview:
- Upstream neighbour of the Huffman insertion sorter.
- Accumulates a per-symbol frequency histogram from a stream of up to two symbols per cycle. Tracks the lowest and highest symbol seen.
- At end of block, hands the histogram, range, meta and seq_id to the sorter with a one-cycle eob pulse, then clears for the next block.
- Back-pressures its producer while a block is being handed off or cleared.

Parameters:
- DAT_WIDTH, 10, symbol width.
- SYM_FREQ_WIDTH, 15, width of each frequency counter.
- CNTRL_WIDTH, 1, meta width.
- MAX_NUM_SYM_USED, 576, number of counters / symbol space.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- in_vld  in  1  input beat valid.
- in_sym_vld  in  2  per-lane valid; bit0 = lane 0, bit1 = lane 1.
- in_sym0  in  DAT_WIDTH  lane 0 symbol.
- in_sym1  in  DAT_WIDTH  lane 1 symbol.
- in_meta  in  CNTRL_WIDTH  block meta, sampled on the last beat.
- in_seq_id  in  `CREOLE_HC_SEQID_WIDTH  block id, sampled on the last beat.
- in_eob  in  e_pipe_eob  MIDDLE = more beats; PASS_THRU = bypass block; any other value = last beat.
- not_ready  out  1  producer must hold the beat while this is high.
- is_not_ready  in  1  not_ready from the sorter.
- fc_is_new_freq  out  MAX_NUM_SYM_USED x SYM_FREQ_WIDTH  histogram.
- fc_is_sym_lo  out  DAT_WIDTH  lowest symbol seen.
- fc_is_sym_hi  out  DAT_WIDTH  highest symbol seen.
- fc_is_meta  out  CNTRL_WIDTH  meta to sorter.
- fc_is_seq_id  out  `CREOLE_HC_SEQID_WIDTH  seq_id to sorter.
- fc_is_eob  out  e_pipe_eob  MIDDLE except during the one-cycle handoff pulse.

Behaviour:
- Reset values:
  - All counters 0; fc_is_sym_lo = MAX_NUM_SYM_USED-1; fc_is_sym_hi = 0.
  - fc_is_meta = 0; fc_is_seq_id = 0; fc_is_eob = MIDDLE.
  - not_ready = 0; state = ACCUM.
  - Reset mid-block discards the block; no eob is emitted.
- A beat is accepted when in_vld & ~not_ready.
- Lane update:
  - A lane counts only if its in_sym_vld bit is set and its symbol < MAX_NUM_SYM_USED. An out-of-range symbol is dropped, and sym_lo/sym_hi ignore it.
  - Both lanes valid with the same symbol: that counter adds 2 in one cycle.
  - Counters saturate at 2^SYM_FREQ_WIDTH-1 and never wrap.
- Range tracking: sym_lo = min and sym_hi = max over counted symbols in the block.
- Empty block: fc_is_sym_lo = 0, fc_is_sym_hi = 0, all frequencies 0.
- FSM:
  - ACCUM: accepted beat with in_eob == MIDDLE → count, stay. Accepted beat with in_eob != MIDDLE → count this beat's lanes (skip counting if PASS_THRU), latch meta, seq_id and eob, go to HANDOFF.
  - HANDOFF: when is_not_ready == 0, drive fc_is_eob = latched eob for exactly one cycle, go to CLEAR. Otherwise hold all outputs stable.
  - CLEAR: zero all counters, reset lo/hi, go to ACCUM.
- not_ready = (state != ACCUM). The beat that ends a block is accepted, and not_ready rises the next cycle.
- Timing:
  - Minimum gap from last beat to the next accepted beat: 3 cycles.
  - fc_is_eob pulses at the earliest 1 cycle after the last beat.
- PASS_THRU:
  - Counts from earlier beats of the block are discarded; fc_is_new_freq = 0, fc_is_sym_lo = 0, fc_is_sym_hi = 0.
  - fc_is_eob = PASS_THRU.
- fc_is_new_freq, fc_is_sym_lo, fc_is_sym_hi, fc_is_meta and fc_is_seq_id are stable from HANDOFF entry through the eob pulse cycle.

Optional Feature:
- Macro: CR_HUF_COMP_SFC_FORCE_EOB_SYM_EN.
- Defined:
  - On a non-PASS_THRU handoff, counter 256 reads at least 1.
  - fc_is_sym_lo and fc_is_sym_hi are widened to include 256, so the deflate EOB code always exists.
- Undefined: no forcing; histogram is exactly as counted.

Decomposition:
- Reuse e_pipe_eob from cr_structs.
- Add to cr_huf_compPKG:
  - state enum e_sfc_state {ACCUM, HANDOFF, CLEAR};
  - localparam SFC_FREQ_MAX.
- One natural sub-module: cr_huf_comp_sfc_lane_merge. It combines the two lanes into per-counter increments (0/1/2), including the same-symbol case, plus the min/max of the beat.

Test Plan:
- Beats (65,66), (65,65), last beat (300, lane 1 invalid) with eob = END, is_not_ready = 0 → freq[65] = 3, freq[66] = 1, freq[300] = 1; lo = 65, hi = 300; one fc_is_eob pulse; not_ready high for 2 cycles after handoff; counters 0 afterwards.
- 40000 beats of symbol 7 on both lanes → freq[7] = 32767 (saturated).
- is_not_ready held high for 10 cycles after last beat → outputs stable, not_ready high; eob pulses on the first cycle is_not_ready = 0.
- Block of symbols 3..9, then PASS_THRU on last beat → fc_is_eob = PASS_THRU, all frequencies 0, lo = hi = 0.
- Symbol 600 on lane 0 and 5 on lane 1 → freq[5] = 1, no other change, lo = hi = 5; rst asserted in the next cycle → all outputs at reset values, no eob.
- Empty block with macro defined → freq[256] = 1, lo = hi = 256; with macro undefined → all zero, lo = hi = 0.
